// File: rtl/sevenseg_ctrl.sv
// N-digit seven-segment controller: hex display, sequential double-dabble
// decimal conversion, leading-zero blanking, per-digit blink and overflow dash.
module sevenseg_ctrl #(
   parameter int DIGITS     = 8,
   parameter int DATA_W     = 32,
   parameter int BLINK_DIV  = 25000000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                mode,
   input  logic                blank_lz,
   input  logic [DIGITS-1:0]   blink_mask,
   output logic                busy,
   output logic                overflow,
   output logic [7*DIGITS-1:0] seg_out,
   output logic                dbg_state
);

   // Handshake: wr_en is taken on a rising edge only while busy is 0 (state IDLE).
   // busy rises after an accepted decimal write and falls on the edge that loads the
   // result; any write seen while busy is 1, including on that falling edge, is dropped.

   localparam int HEX_W   = 4 * DIGITS;
   localparam int BCD_MIN = (DATA_W + 2) / 3;
   localparam int BCD_N   = ((BCD_MIN > DIGITS) ? BCD_MIN : DIGITS) + 1;
   localparam int BCD_W   = 4 * BCD_N;
   localparam int SC_W    = $clog2(DATA_W);
   localparam int BC_W    = $clog2(BLINK_DIV);
   localparam logic [SC_W-1:0] LAST_SHIFT = SC_W'(DATA_W - 1);
   localparam logic [BC_W-1:0] LAST_BLINK = BC_W'(BLINK_DIV - 1);
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_OFF     = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam bit HEX_TRUNC = (DATA_W > HEX_W);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t               r_state;
   logic [DATA_W-1:0]    r_bin;
   logic [BCD_W-1:0]     r_bcd;
   logic [SC_W-1:0]      r_shift;
   logic [HEX_W-1:0]     r_dig;
   logic                 r_shown;
   logic                 r_dash;
   logic                 r_busy;
   logic                 r_ovf;
   logic [BC_W-1:0]      r_blink_cnt;
   logic                 r_phase;
   logic [7*DIGITS-1:0]  r_seg;

   logic [HEX_W-1:0]     w_hex;
   logic [BCD_W-1:0]     w_bcd_adj;
   logic [BCD_W-1:0]     w_bcd_next;
   logic                 w_dec_ovf;
   logic [7*DIGITS-1:0]  w_seg;
   logic                 w_allz;
   logic [6:0]           w_glyph;

   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      case (d)
         4'h0:    f_glyph = 7'b1000000;
         4'h1:    f_glyph = 7'b1111001;
         4'h2:    f_glyph = 7'b0100100;
         4'h3:    f_glyph = 7'b0110000;
         4'h4:    f_glyph = 7'b0011001;
         4'h5:    f_glyph = 7'b0010010;
         4'h6:    f_glyph = 7'b0000010;
         4'h7:    f_glyph = 7'b1111000;
         4'h8:    f_glyph = 7'b0000000;
         4'h9:    f_glyph = 7'b0010000;
         4'hA:    f_glyph = 7'b0001000;
         4'hB:    f_glyph = 7'b0000011;
         4'hC:    f_glyph = 7'b1000110;
         4'hD:    f_glyph = 7'b0100001;
         4'hE:    f_glyph = 7'b0000110;
         default: f_glyph = 7'b0001110;
      endcase
   endfunction

   generate
      if (DATA_W >= HEX_W) begin : g_hex_trunc
         assign w_hex = wr_data[HEX_W-1:0];
      end else begin : g_hex_ext
         assign w_hex = {{(HEX_W - DATA_W){1'b0}}, wr_data};
      end
   endgenerate

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < BCD_N; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   assign w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
   assign w_dec_ovf  = |{w_bcd_adj[BCD_W-1], w_bcd_next[BCD_W-1:HEX_W]};

   // Priority per digit: unwritten/blink blank, then overflow dash, then zero blanking.
   always_comb begin
      w_seg   = '0;
      w_allz  = 1'b1;
      w_glyph = GLYPH_BLANK;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_allz = w_allz & (r_dig[4*k +: 4] == 4'd0);
         if (!r_shown || (r_phase && blink_mask[k]))
            w_glyph = GLYPH_BLANK;
         else if (r_dash)
            w_glyph = GLYPH_DASH;
         else if (blank_lz && w_allz && (k > 0))
            w_glyph = GLYPH_BLANK;
         else
            w_glyph = f_glyph(r_dig[4*k +: 4]);
         w_seg[7*k +: 7] = ACTIVE_LOW ? w_glyph : ~w_glyph;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_shift     <= '0;
         r_dig       <= '0;
         r_shown     <= 1'b0;
         r_dash      <= 1'b0;
         r_busy      <= 1'b0;
         r_ovf       <= 1'b0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_seg       <= {DIGITS{SEG_OFF}};
      end else begin
         r_seg <= w_seg;
         if (r_blink_cnt == LAST_BLINK) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BC_W'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (wr_en && mode) begin
                  r_bin   <= wr_data;
                  r_bcd   <= '0;
                  r_shift <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CONV;
               end else if (wr_en) begin
                  r_dig   <= w_hex;
                  r_shown <= 1'b1;
                  r_dash  <= 1'b0;
                  r_ovf   <= HEX_TRUNC;
               end
            end
            S_CONV: begin
               r_bin   <= r_bin << 1;
               r_bcd   <= w_bcd_next;
               r_shift <= r_shift + SC_W'(1);
               if (r_shift == LAST_SHIFT) begin
                  r_dig   <= w_bcd_next[HEX_W-1:0];
                  r_shown <= 1'b1;
                  r_dash  <= w_dec_ovf;
                  r_ovf   <= w_dec_ovf;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign overflow  = r_ovf;
   assign seg_out   = r_seg;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_sevenseg_ctrl.sv
// Self-checking bench for sevenseg_ctrl: expected displays are queued when a
// write is driven and compared when the DUT presents its registered output.
module tb_sevenseg_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic        mode = 1'b0;
   logic        blank_lz = 1'b0;
   logic [31:0] wr_data = '0;
   logic [7:0]  blink_mask = '0;
   logic        busy;
   logic        overflow;
   logic        dbg_state;
   logic [55:0] seg_out;

   logic [55:0] exp_q[$];
   logic        exp_ovf_q[$];
   int          n_checks = 0;
   int          n_err = 0;

   logic [1:0]  m_cnt;
   logic        m_ph;
   logic        m_ph_d;

   sevenseg_ctrl #(
      .DIGITS(8), .DATA_W(32), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .mode(mode),
      .blank_lz(blank_lz), .blink_mask(blink_mask), .busy(busy),
      .overflow(overflow), .seg_out(seg_out), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference blink phase; m_ph_d is the phase the latest seg_out was built from.
   always @(posedge clk) begin
      if (reset) begin
         m_cnt  <= 2'd0;
         m_ph   <= 1'b0;
         m_ph_d <= 1'b0;
      end else begin
         m_ph_d <= m_ph;
         if (m_cnt == 2'd3) begin
            m_cnt <= 2'd0;
            m_ph  <= ~m_ph;
         end else begin
            m_cnt <= m_cnt + 2'd1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] t[16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[d];
   endfunction

   function automatic logic [55:0] model_seg(input logic [31:0] digs, input bit dash,
                                             input bit lz, input logic [7:0] bmask);
      logic [55:0] s;
      logic [3:0]  d;
      bit          allz;
      s = '0;
      allz = 1'b1;
      for (int k = 7; k >= 0; k--) begin
         d = digs[4*k +: 4];
         allz = allz && (d == 4'd0);
         if (bmask[k])                 s[7*k +: 7] = 7'b1111111;
         else if (dash)                s[7*k +: 7] = 7'b0111111;
         else if (lz && allz && k > 0) s[7*k +: 7] = 7'b1111111;
         else                          s[7*k +: 7] = glyph(d);
      end
      return s;
   endfunction

   function automatic logic [32:0] dec_model(input logic [31:0] v);
      logic [63:0] x;
      logic [31:0] d;
      x = {32'b0, v};
      d = '0;
      for (int k = 0; k < 8; k++) begin
         d[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return {(x != 64'd0), d};
   endfunction

   task automatic pop_check(input string tag);
      logic [55:0] e;
      logic        eo;
      check_eq({tag, "_sb_depth"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         eo = exp_ovf_q.pop_front();
         check_eq({tag, "_seg"}, seg_out, e);
         check_eq({tag, "_ovf"}, overflow, eo);
      end
   endtask

   task automatic do_hex(input logic [31:0] v);
      @(negedge clk);
      wr_en = 1'b1; mode = 1'b0; wr_data = v;
      exp_q.push_back(model_seg(v, 1'b0, blank_lz, 8'h00));
      exp_ovf_q.push_back(1'b0);
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("hex_busy0", busy, 0);
      @(negedge clk);
      check_eq("hex_busy1", busy, 0);
      pop_check("hex");
   endtask

   // inj >= 0: drive an extra hex write of 5 at that many cycles into busy.
   task automatic do_dec(input logic [31:0] v, input int inj);
      logic [32:0] m;
      int          cnt;
      m = dec_model(v);
      @(negedge clk);
      wr_en = 1'b1; mode = 1'b1; wr_data = v;
      exp_q.push_back(model_seg(m[31:0], m[32], blank_lz, 8'h00));
      exp_ovf_q.push_back(m[32]);
      @(negedge clk);
      wr_en = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         if (cnt == inj) begin
            wr_en = 1'b1; mode = 1'b0; wr_data = 32'h5;
         end else begin
            wr_en = 1'b0;
         end
         cnt++;
         @(negedge clk);
      end
      wr_en = 1'b0;
      check_eq("dec_busy_cycles", cnt, 32);
      @(negedge clk);
      check_eq("dec_busy_after", busy, 0);
      pop_check("dec");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_seg", seg_out, {56{1'b1}});
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_state", dbg_state, 0);

      blank_lz = 1'b0;
      do_hex(32'h1234ABCD);
      check_eq("hex_lit", seg_out, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                    7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});

      blank_lz = 1'b1;
      do_dec(32'd12345, -1);
      check_eq("dec_lit", seg_out, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001,
                                    7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010});
      blank_lz = 1'b0;
      @(negedge clk);
      check_eq("lz_off_latency", seg_out, model_seg(32'h00012345, 1'b0, 1'b0, 8'h00));
      blank_lz = 1'b1;

      do_dec(32'hFFFFFFFF, -1);
      check_eq("ovf_dash_lit", seg_out, {8{7'b0111111}});
      do_hex(32'h0);
      check_eq("zero_lit", seg_out, {{7{7'b1111111}}, 7'b1000000});

      do_dec(32'd99, 10);
      do_dec(32'd7, 31);
      do_dec(32'd99999999, -1);
      do_dec(32'd100000000, -1);
      do_dec(32'd10000005, -1);
      do_dec(32'd0, -1);
      blank_lz = 1'b0;
      do_dec(32'd12345, -1);
      repeat (3) do_dec($urandom_range(0, 32'hFFFFFFFF), -1);
      repeat (3) do_hex($urandom);

      do_hex(32'h1234ABCD);
      blink_mask = 8'h01;
      repeat (16) begin
         @(negedge clk);
         exp_q.push_back(model_seg(32'h1234ABCD, 1'b0, 1'b0, m_ph_d ? 8'h01 : 8'h00));
         exp_ovf_q.push_back(1'b0);
         pop_check("blink");
      end
      blink_mask = 8'h00;

      @(negedge clk);
      wr_en = 1'b1; mode = 1'b1; wr_data = 32'd99;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("abort_busy_pre", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_seg", seg_out, {56{1'b1}});
      check_eq("abort_ovf", overflow, 0);
      check_eq("abort_state", dbg_state, 0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("abort_no_result", seg_out, {56{1'b1}});
      check_eq("abort_idle_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
